// File: rtl/draw_port_arbiter_if.sv
// Bundle of the arbiter's requester-side and VGA-side signals.
// The master drives requests and pixels; the slave (arbiter) drives grants and the VGA pixel.
interface draw_port_arbiter_if;
   logic [2:0]  req;
   logic [2:0]  done;
   logic [23:0] x_in;
   logic [20:0] y_in;
   logic [8:0]  col_in;
   logic [2:0]  plot_in;
   logic [2:0]  gnt;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [2:0]  col_out;
   logic        plot_out;
   logic        busy;
   logic [2:0]  timeout_err;

   modport master (
      output req, done, x_in, y_in, col_in, plot_in,
      input  gnt, x_out, y_out, col_out, plot_out, busy, timeout_err
   );

   modport slave (
      input  req, done, x_in, y_in, col_in, plot_in,
      output gnt, x_out, y_out, col_out, plot_out, busy, timeout_err
   );
endinterface

// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter giving three drawing engines exclusive access to the VGA pixel port,
// with a per-grant cycle limit and sticky timeout flags.
module draw_port_arbiter #(
   parameter logic [14:0] TIMEOUT = 15'd24575
) (
   input logic                clk,
   input logic                reset,
   draw_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

   state_e      r_state, w_state_next;
   logic [1:0]  r_last;
   logic [14:0] r_cnt;
   logic [2:0]  r_err;
   logic [7:0]  r_x;
   logic [6:0]  r_y;
   logic [2:0]  r_col;
   logic        r_plot;

   logic [1:0]  w_winner, w_c0, w_c1;
   logic [2:0]  w_gnt_oh, w_err_set;
   logic        w_g_req, w_g_done, w_g_plot;
   logic [7:0]  w_g_x;
   logic [6:0]  w_g_y;
   logic [2:0]  w_g_col;
   logic        w_timeout, w_release, w_in_grant;

   function automatic logic [1:0] nxt(input logic [1:0] i);
      return (i == 2'd0) ? 2'd1 : (i == 2'd1) ? 2'd2 : 2'd0;
   endfunction

   function automatic logic bit_of(input logic [2:0] v, input logic [1:0] i);
      return (i == 2'd0) ? v[0] : (i == 2'd1) ? v[1] : v[2];
   endfunction

   // Search starts one past the last grant so a just-released requester goes last.
   always_comb begin
      w_c0     = nxt(r_last);
      w_c1     = nxt(w_c0);
      w_winner = r_last;
      if (bit_of(bus.req, w_c1)) w_winner = w_c1;
      if (bit_of(bus.req, w_c0)) w_winner = w_c0;
   end

   always_comb begin
      w_gnt_oh = 3'b100;
      w_g_x    = bus.x_in[23:16];
      w_g_y    = bus.y_in[20:14];
      w_g_col  = bus.col_in[8:6];
      unique case (r_last)
         2'd0: begin
            w_gnt_oh = 3'b001;
            w_g_x    = bus.x_in[7:0];
            w_g_y    = bus.y_in[6:0];
            w_g_col  = bus.col_in[2:0];
         end
         2'd1: begin
            w_gnt_oh = 3'b010;
            w_g_x    = bus.x_in[15:8];
            w_g_y    = bus.y_in[13:7];
            w_g_col  = bus.col_in[5:3];
         end
         default: ;
      endcase
   end

   assign w_in_grant = (r_state == StGrant);
   assign w_g_req    = |(bus.req & w_gnt_oh);
   assign w_g_done   = |(bus.done & w_gnt_oh);
   assign w_g_plot   = |(bus.plot_in & w_gnt_oh);
   // True in the cycle whose increment brings the counter up to TIMEOUT.
   assign w_timeout  = ({1'b0, r_cnt} + 16'd1) >= {1'b0, TIMEOUT};
   assign w_release  = w_g_done || !w_g_req || w_timeout;
   assign w_err_set  = (w_in_grant && w_timeout && !w_g_done) ? w_gnt_oh : 3'b000;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (|bus.req) w_state_next = StGrant;
         StGrant: if (w_release) w_state_next = StRelease;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_last  <= 2'd2;
         r_cnt   <= '0;
         r_err   <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_col   <= '0;
         r_plot  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_err   <= r_err | w_err_set;
         if (r_state == StIdle && |bus.req) r_last <= w_winner;
         if (w_in_grant) begin
            r_cnt  <= (&r_cnt) ? r_cnt : r_cnt + 15'd1;
            r_x    <= w_g_x;
            r_y    <= w_g_y;
            r_col  <= w_g_col;
            r_plot <= w_g_plot;
         end else begin
            r_cnt  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
            r_plot <= 1'b0;
         end
      end
   end

   assign bus.gnt         = w_in_grant ? w_gnt_oh : 3'b000;
   assign bus.busy        = (r_state != StIdle);
   assign bus.timeout_err = r_err;
   assign bus.x_out       = r_x;
   assign bus.y_out       = r_y;
   assign bus.col_out     = r_col;
   assign bus.plot_out    = r_plot;
endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench for draw_port_arbiter with a short TIMEOUT so the forced-release path is reachable.
module tb_draw_port_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   draw_port_arbiter_if bus ();

   draw_port_arbiter #(
      .TIMEOUT(15'd16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.req     = 3'b000;
      bus.done    = 3'b000;
      bus.x_in    = '0;
      bus.y_in    = '0;
      bus.col_in  = '0;
      bus.plot_in = 3'b000;
   endtask

   initial begin
      logic [2:0] rr_order [4];
      rr_order = '{3'b001, 3'b010, 3'b100, 3'b001};
      checks = 0;
      errors = 0;
      clear_inputs();

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_plot", 32'(bus.plot_out), 32'h0);
      chk("rst_xout", 32'(bus.x_out), 32'h0);
      chk("rst_err", 32'(bus.timeout_err), 32'h0);
      reset = 1'b0;

      // Single request with one pixel, then done
      bus.req     = 3'b001;
      bus.x_in    = {16'd0, 8'd5};
      bus.y_in    = {14'd0, 7'd7};
      bus.col_in  = {6'd0, 3'b111};
      bus.plot_in = 3'b001;
      tick();
      chk("single_gnt", 32'(bus.gnt), 32'h1);
      chk("single_busy", 32'(bus.busy), 32'h1);
      chk("single_plot_lat", 32'(bus.plot_out), 32'h0);
      tick();
      chk("single_pix", {bus.x_out, bus.y_out, bus.col_out, bus.plot_out},
          {8'd5, 7'd7, 3'b111, 1'b1});
      bus.done = 3'b001;
      tick();
      bus.done    = 3'b000;
      bus.req     = 3'b000;
      bus.plot_in = 3'b000;
      chk("single_rel_gnt", 32'(bus.gnt), 32'h0);
      chk("single_rel_busy", 32'(bus.busy), 32'h1);
      chk("single_done_pix", 32'(bus.plot_out), 32'h1);
      tick();
      chk("single_idle_busy", 32'(bus.busy), 32'h0);
      chk("single_idle_plot", {bus.x_out, bus.plot_out}, 32'h0);

      // Round-robin from fresh reset: 0,1,2,0 with two idle-gnt cycles between grants
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("rr_gnt%0d", i), 32'(bus.gnt), 32'(rr_order[i]));
         bus.done = rr_order[i];
         tick();
         bus.done = 3'b000;
         chk($sformatf("rr_gap_a%0d", i), 32'(bus.gnt), 32'h0);
         tick();
         chk($sformatf("rr_gap_b%0d", i), 32'(bus.gnt), 32'h0);
      end
      bus.req = 3'b000;
      tick();

      // Isolation: requester 1 granted while requester 2 strobes x=99 and pulses done
      bus.req     = 3'b010;
      bus.x_in    = {8'd99, 8'd11, 8'd0};
      bus.plot_in = 3'b110;
      tick();
      chk("iso_gnt", 32'(bus.gnt), 32'h2);
      tick();
      chk("iso_xout", 32'(bus.x_out), 32'd11);
      chk("iso_plot", 32'(bus.plot_out), 32'h1);
      bus.done = 3'b100;
      tick();
      bus.done = 3'b000;
      chk("iso_foreign_done", 32'(bus.gnt), 32'h2);
      chk("iso_xout2", 32'(bus.x_out), 32'd11);
      bus.done = 3'b010;
      tick();
      clear_inputs();
      tick();

      // Timeout: requester 0 holds for 16 GRANT cycles, requester 1 pending
      bus.req = 3'b011;
      tick();
      chk("to_gnt", 32'(bus.gnt), 32'h1);
      for (int i = 0; i < 15; i++) tick();
      chk("to_gnt_last", 32'(bus.gnt), 32'h1);
      chk("to_err_before", 32'(bus.timeout_err), 32'h0);
      tick();
      chk("to_rel_gnt", 32'(bus.gnt), 32'h0);
      chk("to_err", 32'(bus.timeout_err), 32'h1);
      tick();
      tick();
      chk("to_next_gnt", 32'(bus.gnt), 32'h2);
      bus.done = 3'b010;
      tick();
      clear_inputs();
      tick();
      chk("to_err_sticky", 32'(bus.timeout_err), 32'h1);

      // Coincidence of done with timeout, after a reset that clears the flag
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("co_err_cleared", 32'(bus.timeout_err), 32'h0);
      bus.req = 3'b001;
      tick();
      chk("co_gnt", 32'(bus.gnt), 32'h1);
      for (int i = 0; i < 15; i++) tick();
      bus.done = 3'b001;
      tick();
      clear_inputs();
      chk("co_rel_gnt", 32'(bus.gnt), 32'h0);
      chk("co_err", 32'(bus.timeout_err), 32'h0);
      tick();

      // Reset mid-GRANT
      bus.req     = 3'b001;
      bus.x_in    = {16'd0, 8'd5};
      bus.plot_in = 3'b001;
      tick();
      tick();
      chk("mr_plot_pre", 32'(bus.plot_out), 32'h1);
      reset = 1'b1;
      tick();
      chk("mr_state", {bus.gnt, bus.plot_out, bus.busy}, 32'h0);
      reset = 1'b0;
      clear_inputs();
      bus.req = 3'b111;
      tick();
      chk("mr_first_gnt", 32'(bus.gnt), 32'h1);
      clear_inputs();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
